puf_array_eval: RTL and testbench
=================================

# puf_array_eval

Parametrised controller for a PDL PUF array: it sequences N_PUF arbiter channels through a configurable number of evaluations per challenge and majority-votes the raw bits into a stable response. It is the clocked successor to the single-shot trigger/adder mapping. It registers challenge and adder operands, drives the array's reset and fire lines, and samples the arbiter outputs through a synchroniser. It sits between the host challenge interface and the PDL_PUF instances, and reports a per-bit instability flag alongside the response.

## Interface
- N_PUF, 16: number of PUF channels / response bits.
- CH_W, 128: challenge width, broadcast to every channel.
- OP_W, 16: adder operand width; must be ≥ N_PUF.
- EVALS, 5: evaluations per challenge; must be ≥ 1.
- RST_CYC, 2: cycles pdl_reset is held before each fire; must be ≥ 1.
- SETTLE_CYC, 4: cycles pdl_fire is held per evaluation; must be ≥ 3. Violating any parameter rule is an elaboration error.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only in IDLE.
- challenge  in  CH_W  challenge; captured on accept.
- a_op, b_op  in  OP_W  adder operands; captured on accept.
- busy  out  1  high from the cycle after accept through the DONE cycle.
- done  out  1  one-cycle pulse; resp and unstable are valid from this cycle.
- resp  out  N_PUF  majority-voted response; held until the next DONE.
- unstable  out  N_PUF  bit i = 1 if its EVALS samples were not unanimous.
- pdl_challenge  out  CH_W  registered challenge to the array.
- pdl_a, pdl_b  out  OP_W  registered operands to the array adders.
- pdl_reset  out  1  active-high arbiter reset to the array.
- pdl_fire  out  1  launch/trigger to the array.
- resp_in  in  N_PUF  raw arbiter outputs; asynchronous to clk.

## Operation
- States: IDLE, ARM, FIRE, SAMPLE, DONE.
- IDLE with start=1:
  - capture challenge, a_op and b_op into pdl_challenge, pdl_a and pdl_b;
  - clear eval_cnt and all vote counters;
  - go to ARM.
- Captured operands and challenge stay constant until the next accept. start in any state other than IDLE is ignored.
- ARM: pdl_reset=1, pdl_fire=0 for RST_CYC cycles, then go to FIRE.
- FIRE: pdl_reset=0, pdl_fire=1 for SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE (1 cycle):
  - pdl_reset=1, pdl_fire=0;
  - for every i, vote[i] += sync_resp[i];
  - if eval_cnt == EVALS-1, go to DONE; otherwise increment eval_cnt and go to ARM.
- DONE (1 cycle):
  - done=1;
  - resp[i] = (2·vote[i] > EVALS); an even-EVALS tie resolves to 0;
  - unstable[i] = (vote[i] ≠ 0 and vote[i] ≠ EVALS);
  - go to IDLE.
- resp_in passes continuously through a 2-flop synchroniser per bit; SAMPLE uses the second-stage value.
- Vote counters are ceil(log2(EVALS+1)) bits wide per channel and cannot overflow.
- In IDLE: pdl_reset=1, pdl_fire=0.

## Timing
- Reset values (async, while reset=0): state IDLE; busy 0, done 0, resp 0, unstable 0, pdl_challenge 0, pdl_a 0, pdl_b 0, pdl_reset 1, pdl_fire 0. Synchroniser flops, vote counters and eval_cnt are also 0.
- Reset asserted mid-operation aborts immediately. No done pulse is produced and the previous resp is lost (it goes to 0).
- Accept in cycle t; busy rises at t+1.
- One evaluation takes E = RST_CYC + SETTLE_CYC + 1 cycles.
- DONE and the done pulse occur at cycle t + EVALS·E + 1.
- Defaults: E = 7, so done at t+36. busy falls at t+37, which is also the earliest next accept.
- pdl_fire is never high while pdl_reset is high. Both outputs are registered (glitch-free).
- resp and unstable change only in the DONE cycle.

## Test plan
- Reset: hold reset=0 with random inputs → all outputs at their reset values. Release reset with start=0 → stays IDLE; pdl_reset=1, busy=0.
- Stable array, defaults: stub drives resp_in=16'hA5C3 during every FIRE; start at t → done only at t+36, resp=16'hA5C3, unstable=0. pdl_fire high in exactly 5 windows of 4 cycles.
- Majority: bit 0 sampled 1,1,0,1,0 across the evaluations, bit 1 sampled 0,0,0,0,1, all other bits 0 → resp=16'h0001, unstable=16'h0003.
- Even tie: EVALS=4, bit 3 sampled 1,1,0,0 → resp[3]=0, unstable[3]=1.
- Protocol: start asserted every cycle while busy with a changing challenge → pdl_challenge holds the first value, exactly one done per job, next accept at t+37. Reset pulled low at t+20 → no done, all outputs at reset values within that cycle.
- Capture: a_op=16'h1234, b_op=16'h00FF at accept, then changed → pdl_a/pdl_b hold 16'h1234/16'h00FF until the next accept.

Source files
------------

// File: rtl/puf_array_eval.sv
// puf_array_eval
//
// Clocked controller for a PDL PUF array. It runs EVALS arbiter evaluations
// for each challenge and majority-votes the raw bits into a stable response.
// Each evaluation holds the arbiters in reset (ARM), launches the race
// (FIRE), and then takes one synchronised sample per channel (SAMPLE).
// After the last evaluation, DONE publishes the response and a per-bit
// flag that shows which bits did not agree across all evaluations.
//
// Ports:
//   clk            system clock; all state changes on the rising edge
//   reset          asynchronous, active-low reset
//   start          job request; only accepted in IDLE
//   challenge      challenge word; captured when a job is accepted
//   a_op, b_op     adder operands; captured when a job is accepted
//   busy           high from the cycle after accept through the DONE cycle
//   done           one-cycle pulse; resp/unstable are valid from this cycle
//   resp           majority-voted response; held until the next DONE
//   unstable       bit i set when channel i's samples were not unanimous
//   pdl_challenge  registered challenge sent to the array
//   pdl_a, pdl_b   registered adder operands sent to the array
//   pdl_reset      active-high arbiter reset sent to the array
//   pdl_fire       launch/trigger sent to the array
//   resp_in        raw arbiter outputs; asynchronous to clk

module puf_array_eval #(
    parameter int N_PUF      = 16,
    parameter int CH_W       = 128,
    parameter int OP_W       = 16,
    parameter int EVALS      = 5,
    parameter int RST_CYC    = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CH_W-1:0]   challenge,
    input  logic [OP_W-1:0]   a_op,
    input  logic [OP_W-1:0]   b_op,
    output logic              busy,
    output logic              done,
    output logic [N_PUF-1:0]  resp,
    output logic [N_PUF-1:0]  unstable,
    output logic [CH_W-1:0]   pdl_challenge,
    output logic [OP_W-1:0]   pdl_a,
    output logic [OP_W-1:0]   pdl_b,
    output logic              pdl_reset,
    output logic              pdl_fire,
    input  logic [N_PUF-1:0]  resp_in
);

    // A vote counter has to hold the values 0..EVALS.
    localparam int VOTE_W = $clog2(EVALS + 1);
    localparam int EC_W   = (EVALS > 1) ? $clog2(EVALS) : 1;
    localparam int PH_MAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [EC_W-1:0]   LAST_EVAL  = EC_W'(EVALS - 1);
    localparam logic [PH_W-1:0]   ARM_LAST   = PH_W'(RST_CYC - 1);
    localparam logic [PH_W-1:0]   FIRE_LAST  = PH_W'(SETTLE_CYC - 1);
    localparam logic [VOTE_W-1:0] ALL_VOTES  = VOTE_W'(EVALS);
    localparam logic [VOTE_W:0]   EVALS_WIDE = (VOTE_W + 1)'(EVALS);

    // Reject illegal parameter sets when the design is elaborated.
    // SETTLE_CYC >= 3 gives the 2-flop synchroniser time to see the
    // arbiter result before SAMPLE uses it.
    generate
        if (OP_W < N_PUF || EVALS < 1 || RST_CYC < 1 || SETTLE_CYC < 3) begin : g_param_check
            $error("puf_array_eval: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FIRE,
        SAMPLE,
        DONE
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [PH_W-1:0]     phase_cnt;
    logic [EC_W-1:0]     eval_cnt;
    logic [N_PUF-1:0]    sync1;
    logic [N_PUF-1:0]    sync2;
    logic [VOTE_W-1:0]   vote      [N_PUF];
    logic [VOTE_W-1:0]   vote_next [N_PUF];
    logic [N_PUF-1:0]    maj_next;
    logic [N_PUF-1:0]    unst_next;
    logic                accept;

    assign accept = (state == IDLE) && start;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. ARM and FIRE last until phase_cnt reaches the
    // configured length. SAMPLE either starts another evaluation or
    // finishes the job.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ARM;
            ARM:     if (phase_cnt == ARM_LAST) next_state = FIRE;
            FIRE:    if (phase_cnt == FIRE_LAST) next_state = SAMPLE;
            SAMPLE:  next_state = (eval_cnt == LAST_EVAL) ? DONE : ARM;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Votes including the sample being taken this cycle. DONE follows the
    // last SAMPLE, so the response is decided from these values and then
    // registered on the way into DONE.
    always_comb begin
        for (int i = 0; i < N_PUF; i++) begin
            vote_next[i] = vote[i] + VOTE_W'(sync2[i]);
            maj_next[i]  = (({1'b0, vote_next[i]} << 1) > EVALS_WIDE);
            unst_next[i] = (vote_next[i] != '0) && (vote_next[i] != ALL_VOTES);
        end
    end

    // Cycle counter inside ARM and FIRE. It restarts at every state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_cnt <= '0;
        end else if (next_state != state || !(state == ARM || state == FIRE)) begin
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + 1'b1;
        end
    end

    // Evaluation index and per-channel vote counters. Both clear on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eval_cnt <= '0;
            for (int i = 0; i < N_PUF; i++) vote[i] <= '0;
        end else if (accept) begin
            eval_cnt <= '0;
            for (int i = 0; i < N_PUF; i++) vote[i] <= '0;
        end else if (state == SAMPLE) begin
            if (eval_cnt != LAST_EVAL) eval_cnt <= eval_cnt + 1'b1;
            for (int i = 0; i < N_PUF; i++) vote[i] <= vote_next[i];
        end
    end

    // Two-flop synchroniser for the asynchronous arbiter outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= resp_in;
            sync2 <= sync1;
        end
    end

    // Challenge and operands are frozen from accept until the next accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pdl_challenge <= '0;
            pdl_a         <= '0;
            pdl_b         <= '0;
        end else if (accept) begin
            pdl_challenge <= challenge;
            pdl_a         <= a_op;
            pdl_b         <= b_op;
        end
    end

    // Status and array controls are registered from next_state, so they are
    // glitch-free and line up with the state. pdl_fire and pdl_reset are
    // complements of the same condition, so they are never both high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            pdl_fire  <= 1'b0;
            pdl_reset <= 1'b1;
        end else begin
            busy      <= (next_state != IDLE);
            done      <= (next_state == DONE);
            pdl_fire  <= (next_state == FIRE);
            pdl_reset <= (next_state != FIRE);
        end
    end

    // The result registers only change on entry to DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp     <= '0;
            unstable <= '0;
        end else if (state == SAMPLE && next_state == DONE) begin
            resp     <= maj_next;
            unstable <= unst_next;
        end
    end

endmodule

// File: tb/tb_puf_array_eval.sv
// tb_puf_array_eval
//
// Self-checking bench for puf_array_eval. It uses two instances: one with
// the default parameters (EVALS=5) and one with EVALS=4 for even-tie
// behaviour. Both instances share the data inputs and have separate starts.
// A stub inside the job task drives one raw pattern per FIRE window.
// Expected results come from hand-derived table entries or from a
// bit-counting majority model.

module tb_puf_array_eval;

    localparam int N  = 16;
    localparam int CW = 128;
    localparam int OW = 16;
    localparam int SETTLE = 4;
    localparam int EVAL_LEN = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          sel_b = 1'b0;
    logic [CW-1:0] challenge = '0;
    logic [OW-1:0] a_op = '0;
    logic [OW-1:0] b_op = '0;
    logic [N-1:0]  resp_in = '0;

    wire start_a = start & ~sel_b;
    wire start_b = start & sel_b;

    logic          busy_a, done_a, prst_a, pfire_a;
    logic [N-1:0]  resp_a, unst_a;
    logic [CW-1:0] pch_a;
    logic [OW-1:0] pa_a, pb_a;
    logic          busy_b, done_b, prst_b, pfire_b;
    logic [N-1:0]  resp_b, unst_b;
    logic [CW-1:0] pch_b;
    logic [OW-1:0] pa_b, pb_b;

    puf_array_eval dut_a (
        .clk(clk), .reset(reset), .start(start_a), .challenge(challenge),
        .a_op(a_op), .b_op(b_op), .busy(busy_a), .done(done_a),
        .resp(resp_a), .unstable(unst_a), .pdl_challenge(pch_a),
        .pdl_a(pa_a), .pdl_b(pb_a), .pdl_reset(prst_a), .pdl_fire(pfire_a),
        .resp_in(resp_in)
    );

    puf_array_eval #(.EVALS(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .challenge(challenge),
        .a_op(a_op), .b_op(b_op), .busy(busy_b), .done(done_b),
        .resp(resp_b), .unstable(unst_b), .pdl_challenge(pch_b),
        .pdl_a(pa_b), .pdl_b(pb_b), .pdl_reset(prst_b), .pdl_fire(pfire_b),
        .resp_in(resp_in)
    );

    // The m_* signals show whichever instance the current job targets.
    wire          m_busy = sel_b ? busy_b  : busy_a;
    wire          m_done = sel_b ? done_b  : done_a;
    wire          m_rst  = sel_b ? prst_b  : prst_a;
    wire          m_fire = sel_b ? pfire_b : pfire_a;
    wire [N-1:0]  m_resp = sel_b ? resp_b  : resp_a;
    wire [N-1:0]  m_unst = sel_b ? unst_b  : unst_a;
    wire [CW-1:0] m_pch  = sel_b ? pch_b   : pch_a;
    wire [OW-1:0] m_pa   = sel_b ? pa_b    : pa_a;
    wire [OW-1:0] m_pb   = sel_b ? pb_b    : pb_a;

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [N-1:0] prev_resp [2];
    logic [N-1:0] prev_unst [2];

    typedef struct {
        logic [4:0][15:0] pats;
        int               n_ev;
        logic             sel;
        logic [15:0]      a;
        logic [15:0]      b;
        logic [15:0]      exp_resp;
        logic [15:0]      exp_unst;
    } vec_t;

    vec_t vecs [8];

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Evaluation e uses pattern p<e>.
    function automatic logic [4:0][15:0] mk(input logic [15:0] p0, p1, p2, p3, p4);
        return {p4, p3, p2, p1, p0};
    endfunction

    // Reference: count the ones per bit over the evaluations, then take the
    // strict majority. Mark a bit unstable when its count is neither zero
    // nor full.
    function automatic logic [31:0] model(input logic [4:0][15:0] pats, input int n);
        logic [15:0] r;
        logic [15:0] u;
        r = '0;
        u = '0;
        for (int i = 0; i < 16; i++) begin
            int ones;
            ones = 0;
            for (int e = 0; e < n; e++) ones += int'(pats[e][i]);
            r[i] = (2 * ones > n);
            u[i] = (ones != 0) && (ones != n);
        end
        return {r, u};
    endfunction

    function automatic logic [CW-1:0] rand_ch();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_reset_vals(input string tag);
        check_output({tag, "_busy"},  busy_a,  0);
        check_output({tag, "_done"},  done_a,  0);
        check_output({tag, "_resp"},  resp_a,  0);
        check_output({tag, "_unst"},  unst_a,  0);
        check_output({tag, "_pch"},   pch_a,   0);
        check_output({tag, "_pa"},    pa_a,    0);
        check_output({tag, "_pb"},    pb_a,    0);
        check_output({tag, "_prst"},  prst_a,  1);
        check_output({tag, "_pfire"}, pfire_a, 0);
    endtask

    // Runs one complete job on the selected instance, starting in the
    // current (IDLE) cycle t. It checks done timing, the busy window, the
    // held captures, the fire windows and the result. With spam set, start
    // stays high the whole time and is still high when the task returns.
    task automatic apply_stimulus(input logic [4:0][15:0] pats, input int n_ev,
                                  input logic [CW-1:0] ch, input logic [15:0] a,
                                  input logic [15:0] b, input bit spam,
                                  input logic [15:0] exp_resp, input logic [15:0] exp_unst);
        int   last;
        int   idx;
        int   done_at;
        int   n_done;
        int   fire_cyc;
        int   windows;
        int   w;
        int   busy_bad;
        int   hold_bad;
        int   excl_bad;
        int   moved;
        logic prev_fire;
        last = n_ev * EVAL_LEN + 1;
        idx = sel_b ? 1 : 0;
        done_at = -1;
        n_done = 0;
        fire_cyc = 0;
        windows = 0;
        w = 0;
        busy_bad = 0;
        hold_bad = 0;
        excl_bad = 0;
        moved = 0;
        prev_fire = 1'b0;
        challenge = ch;
        a_op = a;
        b_op = b;
        start = 1'b1;
        for (int k = 1; k <= last + 1; k++) begin
            @(negedge clk);
            if (m_busy !== (k <= last)) busy_bad++;
            if (m_pch !== ch || m_pa !== a || m_pb !== b) hold_bad++;
            if (m_fire === 1'b1 && m_rst === 1'b1) excl_bad++;
            if (m_fire === 1'b1) fire_cyc++;
            if (m_fire === 1'b1 && !prev_fire) begin
                windows++;
                resp_in = pats[w];
                if (w < 4) w++;
            end
            if (m_fire !== 1'b1 && prev_fire) resp_in = $urandom;
            prev_fire = (m_fire === 1'b1);
            if (m_done === 1'b1) begin
                n_done++;
                done_at = k;
                check_output("resp", m_resp, exp_resp);
                check_output("unstable", m_unst, exp_unst);
                prev_resp[idx] = exp_resp;
                prev_unst[idx] = exp_unst;
            end else if (m_resp !== prev_resp[idx] || m_unst !== prev_unst[idx]) begin
                moved++;
            end
            start = spam;
            challenge = rand_ch();
            a_op = $urandom;
            b_op = $urandom;
        end
        check_output("done_count", n_done, 1);
        check_output("done_cycle", done_at, last);
        check_output("fire_cycles", fire_cyc, n_ev * SETTLE);
        check_output("fire_windows", windows, n_ev);
        check_output("busy_window_errs", busy_bad, 0);
        check_output("capture_hold_errs", hold_bad, 0);
        check_output("fire_reset_overlap", excl_bad, 0);
        check_output("resp_changed_early", moved, 0);
    endtask

    initial begin
        int early_done;
        logic [4:0][15:0] p;
        logic [31:0] m;

        prev_resp[0] = '0; prev_resp[1] = '0;
        prev_unst[0] = '0; prev_unst[1] = '0;

        vecs[0] = '{mk(16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3), 5, 1'b0, 16'h1234, 16'h00FF, 16'hA5C3, 16'h0000};
        vecs[1] = '{mk(16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h0002), 5, 1'b0, 16'h1111, 16'h2222, 16'h0001, 16'h0003};
        vecs[2] = '{mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 5, 1'b0, 16'hBEEF, 16'h0001, 16'hFFFF, 16'h0000};
        vecs[3] = '{mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000), 5, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        vecs[4] = '{mk(16'h00FF, 16'hFF00, 16'h00FF, 16'hFF00, 16'h00FF), 5, 1'b0, 16'h5A5A, 16'hA5A5, 16'h00FF, 16'hFFFF};
        vecs[5] = '{mk(16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'hF0F0), 5, 1'b0, 16'h0F0F, 16'hF0F0, 16'h0F0F, 16'hFFFF};
        vecs[6] = '{mk(16'h0008, 16'h0008, 16'h0000, 16'h0000, 16'hFFFF), 4, 1'b1, 16'h7777, 16'h8888, 16'h0000, 16'h0008};
        vecs[7] = '{mk(16'h0003, 16'h0001, 16'h0001, 16'h0000, 16'hFFFF), 4, 1'b1, 16'h4321, 16'h8765, 16'h0001, 16'h0003};

        // Hold reset with random inputs, then release it with start low.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = $urandom_range(0, 1);
            challenge = rand_ch();
            a_op = $urandom;
            b_op = $urandom;
            resp_in = $urandom;
        end
        check_reset_vals("in_reset");
        start = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_output("idle_pdl_reset", prst_a, 1);
        check_output("idle_busy", busy_a, 0);
        check_output("idle_pdl_fire", pfire_a, 0);

        // Directed table: default instance first, then the EVALS=4 instance.
        for (int v = 0; v < 8; v++) begin
            sel_b = vecs[v].sel;
            @(negedge clk);
            apply_stimulus(vecs[v].pats, vecs[v].n_ev, rand_ch(), vecs[v].a, vecs[v].b,
                           1'b0, vecs[v].exp_resp, vecs[v].exp_unst);
        end

        // Random patterns checked against the counting model.
        for (int j = 0; j < 8; j++) begin
            sel_b = (j >= 5);
            p = mk($urandom, $urandom, $urandom, $urandom, $urandom);
            m = model(p, sel_b ? 4 : 5);
            @(negedge clk);
            apply_stimulus(p, sel_b ? 4 : 5, rand_ch(), $urandom, $urandom, 1'b0, m[31:16], m[15:0]);
        end

        // Start held high throughout a job. Afterwards the follow-up accept
        // happens at t+37 and is aborted by reset at t'+20.
        sel_b = 1'b0;
        @(negedge clk);
        apply_stimulus(vecs[0].pats, 5, rand_ch(), 16'h1234, 16'h00FF, 1'b1, 16'hA5C3, 16'h0000);
        @(negedge clk);
        start = 1'b0;
        check_output("reaccept_busy", busy_a, 1);
        early_done = 0;
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            if (done_a === 1'b1) early_done++;
        end
        reset = 1'b0;
        #1;
        check_reset_vals("abort");
        repeat (2) @(negedge clk);
        if (done_a === 1'b1) early_done++;
        check_output("abort_no_done", early_done, 0);
        reset = 1'b1;
        prev_resp[0] = '0; prev_unst[0] = '0;
        prev_resp[1] = '0; prev_unst[1] = '0;

        // Normal operation resumes after the abort.
        p = mk($urandom, $urandom, $urandom, $urandom, $urandom);
        m = model(p, 5);
        @(negedge clk);
        apply_stimulus(p, 5, rand_ch(), $urandom, $urandom, 1'b0, m[31:16], m[15:0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
